// File: rtl/dcache_mem_responder.sv
// -----------------------------------------------------------------------------
// dcache_mem_responder
//
// Memory-side end of the data cache line interface. Takes one line request at
// a time from the write-back data cache. A request is either a refill (line
// read) or a writeback (line write). The line is split into ascending
// word-wide beats on a request/acknowledge backing-memory bus. Refill words
// are assembled into a registered line. One acknowledge is returned per line.
//
// Ports
//   clk, rst_n           clock, asynchronous active-low reset
//   dcache2mem_req_i     line request, held until mem2dcache_ack_o
//   dcache2mem_wr_i      1 = writeback, 0 = refill (valid with req)
//   dcache2mem_addr_i    line byte address (offset bits ignored)
//   dcache2mem_data_i    writeback line (valid with req)
//   mem2dcache_data_o    assembled refill line (registered)
//   mem2dcache_ack_o     one-cycle line-complete pulse
//   mem2dcache_err_o     one-cycle pulse with ack when a beat timed out
//   mem_req_o/mem_we_o   beat request / write enable to backing memory
//   mem_addr_o           beat byte address
//   mem_wdata_o          beat write data
//   mem_rdata_i          beat read data, valid with mem_ack_i
//   mem_ack_i            beat complete (may arrive in the first request cycle)
// -----------------------------------------------------------------------------
module dcache_mem_responder #(
  parameter int ADDR_WIDTH     = 32,
  parameter int LINE_WIDTH     = 128,
  parameter int WORD_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  dcache2mem_req_i,
  input  logic                  dcache2mem_wr_i,
  input  logic [ADDR_WIDTH-1:0] dcache2mem_addr_i,
  input  logic [LINE_WIDTH-1:0] dcache2mem_data_i,
  output logic [LINE_WIDTH-1:0] mem2dcache_data_o,
  output logic                  mem2dcache_ack_o,
  output logic                  mem2dcache_err_o,
  output logic                  mem_req_o,
  output logic                  mem_we_o,
  output logic [ADDR_WIDTH-1:0] mem_addr_o,
  output logic [WORD_WIDTH-1:0] mem_wdata_o,
  input  logic [WORD_WIDTH-1:0] mem_rdata_i,
  input  logic                  mem_ack_i
);

  localparam int BEATS    = LINE_WIDTH / WORD_WIDTH;
  localparam int BEAT_W   = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int LINE_OFF = $clog2(LINE_WIDTH / 8);
  localparam int WORD_OFF = $clog2(WORD_WIDTH / 8);

  localparam logic [BEAT_W-1:0] LAST_BEAT  = BEAT_W'(BEATS - 1);
  localparam logic [7:0]        TIMER_LAST = 8'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_XFER = 2'd1,
    S_RESP = 2'd2
  } state_t;

  state_t                  state_q, state_d;
  logic                    wr_q, wr_d;
  logic [ADDR_WIDTH-1:0]   base_q, base_d;
  logic [LINE_WIDTH-1:0]   line_q, line_d;
  logic [BEAT_W-1:0]       beat_q, beat_d;
  logic [7:0]              timer_q, timer_d;
  logic                    err_q, err_d;
  logic [LINE_WIDTH-1:0]   data_q, data_d;

  // Offset bits of the incoming address are deliberately discarded.
  logic unused_addr_bits;
  assign unused_addr_bits = ^dcache2mem_addr_i[LINE_OFF-1:0];

  // Word view of the latched writeback line; word i is bits [i*W +: W].
  logic [WORD_WIDTH-1:0] line_word [BEATS];

  generate
    for (genvar gi = 0; gi < BEATS; gi++) begin : g_line_word
      assign line_word[gi] = line_q[gi*WORD_WIDTH +: WORD_WIDTH];
    end
  endgenerate

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      wr_q    <= 1'b0;
      base_q  <= '0;
      line_q  <= '0;
      beat_q  <= '0;
      timer_q <= '0;
      err_q   <= 1'b0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      wr_q    <= wr_d;
      base_q  <= base_d;
      line_q  <= line_d;
      beat_q  <= beat_d;
      timer_q <= timer_d;
      err_q   <= err_d;
      data_q  <= data_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    wr_d    = wr_q;
    base_d  = base_q;
    line_d  = line_q;
    beat_d  = beat_q;
    timer_d = timer_q;
    err_d   = err_q;
    data_d  = data_q;

    unique case (state_q)
      S_IDLE: begin
        if (dcache2mem_req_i) begin
          wr_d    = dcache2mem_wr_i;
          base_d  = {dcache2mem_addr_i[ADDR_WIDTH-1:LINE_OFF], {LINE_OFF{1'b0}}};
          line_d  = dcache2mem_data_i;
          beat_d  = '0;
          timer_d = '0;
          err_d   = 1'b0;
          // A refill starts from a clean line so that beats lost to a
          // timeout read back as zero.
          if (!dcache2mem_wr_i) begin
            data_d = '0;
          end
          state_d = S_XFER;
        end
      end

      S_XFER: begin
        if (mem_ack_i) begin
          if (!wr_q) begin
            for (int i = 0; i < BEATS; i++) begin
              if (beat_q == BEAT_W'(i)) begin
                data_d[i*WORD_WIDTH +: WORD_WIDTH] = mem_rdata_i;
              end
            end
          end
          beat_d  = beat_q + BEAT_W'(1);
          timer_d = '0;
          if (beat_q == LAST_BEAT) begin
            state_d = S_RESP;
          end
        end else if (timer_q == TIMER_LAST) begin
          err_d   = 1'b1;
          state_d = S_RESP;
        end else begin
          timer_d = timer_q + 8'd1;
        end
      end

      S_RESP: begin
        // Returning to IDLE unconditionally means a request still held in
        // this cycle is only seen again one cycle later.
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Outputs: beat bus is driven only while transferring, zero otherwise.
  // ---------------------------------------------------------------------------
  always_comb begin
    mem_req_o   = 1'b0;
    mem_we_o    = 1'b0;
    mem_addr_o  = '0;
    mem_wdata_o = '0;
    if (state_q == S_XFER) begin
      mem_req_o   = 1'b1;
      mem_we_o    = wr_q;
      mem_addr_o  = base_q + (ADDR_WIDTH'(beat_q) << WORD_OFF);
      mem_wdata_o = line_word[beat_q];
    end
  end

  assign mem2dcache_ack_o  = (state_q == S_RESP);
  assign mem2dcache_err_o  = (state_q == S_RESP) && err_q;
  assign mem2dcache_data_o = data_q;

endmodule

// File: doc/dcache_mem_responder.md
Name: dcache_mem_responder

Overview:
- Memory-side end of the data cache line interface. Accepts one line request at a time from the write-back data cache: either a refill (line read) or a writeback (line write).
- Serialises each line into word-wide beats on a simple request/acknowledge backing-memory bus, assembles refill data, and returns one acknowledge per line.
- Sits between the data cache controller/datapath and the main memory or bus bridge.

Parameters:
ADDR_WIDTH, 32, byte address width on both sides
LINE_WIDTH, 128, cache line width in bits
WORD_WIDTH, 32, backing-memory beat width in bits (LINE_WIDTH/WORD_WIDTH = BEATS, power of two)
TIMEOUT_CYCLES, 255, max wait cycles per beat before abort (1..255)

Ports:
clk  input  1  clock
rst_n  input  1  asynchronous active-low reset
dcache2mem_req_i  input  1  line request, held high until mem2dcache_ack_o
dcache2mem_wr_i  input  1  1 = writeback, 0 = refill; valid with req
dcache2mem_addr_i  input  ADDR_WIDTH  line address; offset bits ignored
dcache2mem_data_i  input  LINE_WIDTH  writeback line; valid with req
mem2dcache_data_o  output  LINE_WIDTH  assembled refill line
mem2dcache_ack_o  output  1  one-cycle line-complete pulse
mem2dcache_err_o  output  1  one-cycle pulse with ack on timeout abort
mem_req_o  output  1  beat request to backing memory
mem_we_o  output  1  beat write enable
mem_addr_o  output  ADDR_WIDTH  beat byte address
mem_wdata_o  output  WORD_WIDTH  beat write data
mem_rdata_i  input  WORD_WIDTH  beat read data, valid with mem_ack_i
mem_ack_i  input  1  beat complete; may assert in first cycle of mem_req_o

Behaviour:
- Clock is clk. Reset is rst_n, asynchronous and active-low. On reset every output is 0, the FSM goes to IDLE, and the beat and timeout counters clear.
- Reset mid-transfer aborts immediately. No ack is produced for the aborted line.
- FSM states: IDLE, XFER, RESP.
- IDLE, req=1 at edge: latch wr, base address with low log2(LINE_WIDTH/8) bits forced to 0, and write line. Set beat=0 and timer=0. If wr=0, clear mem2dcache_data_o. Go to XFER.
- XFER outputs: mem_req_o=1, mem_we_o=latched wr, mem_addr_o=base + beat*(WORD_WIDTH/8), mem_wdata_o=line[beat*WORD_WIDTH +: WORD_WIDTH].
- XFER, mem_ack_i=1:
  - On a read, store mem_rdata_i into mem2dcache_data_o[beat*WORD_WIDTH +: WORD_WIDTH].
  - Increment beat and clear timer.
  - If beat==BEATS-1, go to RESP. mem_req_o drops in the next cycle.
- XFER, mem_ack_i=0: increment timer. If timer==TIMEOUT_CYCLES-1, set the error flag and go to RESP.
- RESP: mem2dcache_ack_o=1 for exactly one cycle. mem2dcache_err_o is 1 in the same cycle if the line was aborted. Unreceived refill beats remain 0. Then go to IDLE.
- mem2dcache_data_o is registered. It is stable from the RESP cycle until the next accepted refill. A writeback does not alter it.
- Requests are evaluated only in IDLE. req still high in the RESP cycle is not re-accepted. The earliest re-acceptance is the cycle after RESP.
- mem_ack_i outside XFER is ignored.
- Beat order is ascending. Word i maps to bits [32i+31:32i], matching the cache offset-to-word mapping.
- Minimum latency with single-cycle memory (ack in every XFER cycle): req sampled at edge E0, beats complete at E1..E4 (BEATS=4), mem2dcache_ack_o high in cycle E4..E5. That is 5 cycles from request to ack.
- Counter widths: beat counter is log2(BEATS) bits; timeout counter is 8 bits.
- Inputs changing during XFER have no effect; the latched copies are used.

Test Plan:
- Refill, zero-wait memory: req=1, wr=0, addr=0x0000_1234. Memory returns 0xA0,0xA1,0xA2,0xA3 on addr 0x1230,0x1234,0x1238,0x123C. Required: ack 5 cycles after request, data_o=0x000000A3_000000A2_000000A1_000000A0, err=0.
- Writeback with 2 wait cycles per beat: wr=1, addr=0x8000_0040, data=0x44444444_33333333_22222222_11111111. Required: beats write 0x11111111..0x44444444 to 0x80000040..0x8000004C with mem_we_o=1; ack after 13 cycles; data_o unchanged.
- Timeout: refill where memory acks beats 0 and 1, then never acks. Required: ack and err pulse together in the cycle after 255 wait cycles; data_o upper 64 bits = 0; mem_req_o=0 afterwards.
- Back-to-back: req held high across RESP then a new address. Required: exactly one ack per line and no duplicate transfer; the second line starts in the cycle after RESP.
- Reset mid-transfer: assert rst_n=0 during beat 2 of a refill. Required: all outputs 0 asynchronously and no ack; a subsequent refill completes normally.
- Stray mem_ack_i in IDLE with rdata=0xDEADBEEF. Required: data_o unchanged and no state change.
